zp_stream: RTL and testbench



---
 rtl/cnn_pkg.sv | 30 +++
 rtl/zp_pos_cnt.sv | 59 +++++
 rtl/zp_stream.sv | 87 ++++++++
 tb/tb_zp_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN feature-map path: padded extents, counter
// widths and the packed pixel layout used by the streaming stages.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_C          = 1;
    localparam int DEF_BEAT_W     = DEF_C * DEF_DATA_WIDTH;

    // Lane k of a beat lives at [k*DATA_WIDTH +: DATA_WIDTH].
    typedef logic [DEF_C-1:0][DEF_DATA_WIDTH-1:0] pix_t;

    // Never returns 0 so a 1-pixel extent still gets a real counter bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int padded(input int extent, input int pad);
        return extent + 2 * pad;
    endfunction

    function automatic int beat_width(input int c, input int dw);
        return c * dw;
    endfunction

endpackage

// File: rtl/zp_pos_cnt.sv
// Raster position counter over the padded map, with interior and
// frame/line marker decode for the beat about to be generated.
module zp_pos_cnt
    import cnn_pkg::*;
#(
    parameter int W = 32,
    parameter int H = 32,
    parameter int P = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic interior,
    output logic at_origin,
    output logic at_eol,
    output logic at_eof
);

    localparam int PW = padded(W, P);
    localparam int PH = padded(H, P);
    localparam int XW = clog2(PW);
    localparam int YW = clog2(PH);
    localparam logic [XW-1:0] X_LAST = XW'(PW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(PH - 1);

    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    always_ff @(posedge clk) begin
        if (rst) begin
            ox <= '0;
            oy <= '0;
        end else if (step) begin
            if (ox == X_LAST) begin
                ox <= '0;
                oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    assign at_origin = (ox == '0) && (oy == '0);
    assign at_eol    = (ox == X_LAST);
    assign at_eof    = at_eol && (oy == Y_LAST);

    generate
        if (P == 0) begin : g_no_pad
            assign interior = 1'b1;
        end else begin : g_pad
            localparam logic [XW-1:0] X_LO = XW'(P);
            localparam logic [XW-1:0] X_HI = XW'(W + P);
            localparam logic [YW-1:0] Y_LO = YW'(P);
            localparam logic [YW-1:0] Y_HI = YW'(H + P);
            assign interior = (ox >= X_LO) && (ox < X_HI) && (oy >= Y_LO) && (oy < Y_HI);
        end
    endgenerate

endmodule

// File: rtl/zp_stream.sv
// Streaming zero-padding stage: wraps an H x W raster stream in a P-pixel
// border through a single back-pressurable output register.
module zp_stream
    import cnn_pkg::*;
#(
    parameter int W          = 32,
    parameter int H          = 32,
    parameter int DATA_WIDTH = 8,
    parameter int C          = 1,
    parameter int P          = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pad_val,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [C*DATA_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [C*DATA_WIDTH-1:0] out_data,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    busy
);

    localparam int BW = beat_width(C, DATA_WIDTH);

    logic                  interior;
    logic                  at_origin;
    logic                  at_eol;
    logic                  at_eof;
    logic                  adv;
    logic                  gen;
    logic                  step;
    logic [DATA_WIDTH-1:0] pad_q;
    logic [DATA_WIDTH-1:0] pad_now;
    logic [BW-1:0]         border_beat;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && interior && !rst;
    assign gen      = adv && (!interior || in_valid);
    assign step     = gen && !rst;

    // The origin beat must already carry the new frame's pad value.
    assign pad_now     = at_origin ? pad_val : pad_q;
    assign border_beat = {C{pad_now}};

    zp_pos_cnt #(
        .W (W),
        .H (H),
        .P (P)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .interior  (interior),
        .at_origin (at_origin),
        .at_eol    (at_eol),
        .at_eof    (at_eof)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            pad_q     <= '0;
        end else if (adv) begin
            out_valid <= gen;
            if (gen) begin
                out_data <= interior ? in_data : border_beat;
                out_sof  <= at_origin;
                out_eol  <= at_eol;
                out_eof  <= at_eof;
            end
            if (gen && at_origin) begin
                pad_q <= pad_val;
            end
        end
    end

    assign busy = !at_origin || out_valid;

endmodule

// File: tb/tb_zp_stream.sv
// Self-checking bench for zp_stream: two configurations (padded multi-lane
// and P=0 pass-through) compared beat by beat against a frame-level model.
module tb_zp_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input int cfg_id,
                               input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg_id, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int CW = (g == 0) ? 3 : 2;
        localparam int CH = (g == 0) ? 4 : 2;
        localparam int CP = (g == 0) ? 2 : 0;
        localparam int CC = (g == 0) ? 3 : 1;
        localparam int BW = CC * 8;
        localparam int PW = CW + 2 * CP;
        localparam int PH = CH + 2 * CP;
        localparam int NB = PW * PH;
        localparam int LIT_IDX = (g == 0) ? 16 : 3;
        localparam int RST_IDX = (NB > 10) ? 10 : 2;
        localparam logic [31:0] LIT_FIRST = (g == 0) ? 32'h7F7F7F : 32'h01;
        localparam logic [31:0] LIT_VAL   = (g == 0) ? 32'h030201 : 32'h04;
        localparam logic [31:0] LIT_F1    = (g == 0) ? 32'h111111 : 32'h05;

        logic          rst       = 1'b1;
        logic [7:0]    pad_val   = 8'h7F;
        logic          in_valid  = 1'b0;
        logic          in_ready;
        logic [BW-1:0] in_data   = '0;
        logic          out_valid;
        logic          out_ready = 1'b0;
        logic [BW-1:0] out_data;
        logic          out_sof;
        logic          out_eol;
        logic          out_eof;
        logic          busy;

        zp_stream #(
            .W          (CW),
            .H          (CH),
            .DATA_WIDTH (8),
            .C          (CC),
            .P          (CP)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .pad_val   (pad_val),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_sof   (out_sof),
            .out_eol   (out_eol),
            .out_eof   (out_eof),
            .busy      (busy)
        );

        logic [BW-1:0] acc_q[$];
        int            idx         = 0;
        int            frames      = 0;
        int            n_acc       = 0;
        int            cyc         = -1;
        int            n_resets    = 0;
        int            pad_changes = 0;
        bit            pad_armed   = 1'b0;
        logic [7:0]    cur_pad     = 8'h7F;
        logic [7:0]    next_pad    = 8'h7F;
        bit            exp_known   = 1'b0;
        bit            exp_valid   = 1'b0;
        bit            prev_stall  = 1'b0;
        logic [BW-1:0] prev_data   = '0;
        logic [2:0]    prev_mk     = '0;
        logic          rst_edge    = 1'b0;
        bit            done        = 1'b0;

        function automatic bit border_at(input int n);
            int x;
            int y;
            x = n % PW;
            y = n / PW;
            return !(x >= CP && x < CW + CP && y >= CP && y < CH + CP);
        endfunction

        function automatic logic [BW-1:0] pix(input int n);
            logic [BW-1:0] v;
            v = '0;
            for (int k = 0; k < CC; k++) v[k*8 +: 8] = 8'(n * CC + k + 1);
            return v;
        endfunction

        function automatic logic [BW-1:0] rep(input logic [7:0] p);
            logic [BW-1:0] v;
            v = '0;
            for (int k = 0; k < CC; k++) v[k*8 +: 8] = p;
            return v;
        endfunction

        always @(posedge clk) rst_edge <= rst;

        // Model: the padded frame is the raster of border pad values with the
        // accepted input pixels filling the interior in arrival order.
        always @(negedge clk) begin : compare
            int            gpos;
            int            x;
            logic [BW-1:0] exp_d;
            if (rst_edge) begin
                checkOutput("rst_out_valid", g, 32'(out_valid), 32'd0);
                checkOutput("rst_busy", g, 32'(busy), 32'd0);
                checkOutput("rst_out_data", g, 32'(out_data), 32'd0);
                checkOutput("rst_markers", g, {29'b0, out_sof, out_eol, out_eof}, 32'd0);
                if (rst) checkOutput("rst_in_ready", g, 32'(in_ready), 32'd0);
            end
            if (rst) begin
                acc_q.delete();
                idx        = 0;
                cyc        = -1;
                exp_known  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                cyc++;
                gpos = (idx + (out_valid ? 1 : 0)) % NB;
                if (exp_known) checkOutput("out_valid", g, 32'(out_valid), 32'(exp_valid));
                if (prev_stall) begin
                    checkOutput("hold_data", g, 32'(out_data), 32'(prev_data));
                    checkOutput("hold_markers", g, {29'b0, out_sof, out_eol, out_eof}, {29'b0, prev_mk});
                end
                checkOutput("in_ready", g, 32'(in_ready), 32'((!out_valid || out_ready) && !border_at(gpos)));
                checkOutput("busy", g, 32'(busy), 32'(out_valid || gpos != 0));
                if (n_resets == 0 && cyc == 0) checkOutput("lit_idle_first_cycle", g, 32'(out_valid), 32'd0);
                if (n_resets == 0 && cyc == 1) checkOutput("lit_sof_first_beat", g, {30'b0, out_valid, out_sof}, 32'd3);
                if (out_valid && out_ready) begin
                    if (idx == 0) cur_pad = next_pad;
                    x = idx % PW;
                    exp_d = '0;
                    if (border_at(idx)) begin
                        exp_d = rep(cur_pad);
                    end else if (acc_q.size() == 0) begin
                        checkOutput("input_underflow", g, 32'd1, 32'd0);
                    end else begin
                        exp_d = acc_q.pop_front();
                    end
                    checkOutput("data", g, 32'(out_data), 32'(exp_d));
                    checkOutput("markers", g, {29'b0, out_sof, out_eol, out_eof},
                                {29'b0, idx == 0, x == PW - 1, idx == NB - 1});
                    if (frames == 0 && idx == 0)       checkOutput("lit_first_beat", g, 32'(out_data), LIT_FIRST);
                    if (frames == 0 && idx == LIT_IDX) checkOutput("lit_interior", g, 32'(out_data), LIT_VAL);
                    if (frames == 1 && idx == 0)       checkOutput("lit_next_frame", g, 32'(out_data), LIT_F1);
                    idx++;
                    if (idx == NB) begin
                        idx = 0;
                        frames++;
                    end
                end
                if (n_resets == 0 && cyc == NB) checkOutput("lit_full_rate_frame", g, 32'(frames * 1000 + idx), 32'd1000);
                if (in_valid && in_ready) begin
                    acc_q.push_back(in_data);
                    n_acc++;
                end
                exp_valid  = (!out_valid || out_ready) ? (border_at(gpos) || in_valid) : 1'b1;
                exp_known  = 1'b1;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_mk    = {out_sof, out_eol, out_eof};
            end
        end

        task automatic applyStimulus(input int iv_pct, input int or_pct, input bit toggle);
            @(posedge clk);
            #1;
            in_valid  = toggle ? !in_valid : ($urandom_range(99) < iv_pct);
            out_ready = ($urandom_range(99) < or_pct);
            in_data   = (n_acc < 64) ? pix(n_acc) : BW'($urandom);
            if (pad_armed && idx >= 5 && idx <= NB - 5) begin
                pad_armed = 1'b0;
                pad_val   = (pad_changes == 0) ? 8'h11 : 8'($urandom);
                next_pad  = pad_val;
                pad_changes++;
            end
            if (idx < 5) pad_armed = 1'b1;
        endtask

        initial begin : stim
            int waited;
            repeat (3) @(posedge clk);
            #1;
            rst       = 1'b0;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_data   = pix(0);
            for (int i = 0; i < NB + 4; i++) applyStimulus(100, 100, 1'b0);
            for (int i = 0; i < 2 * NB + 8; i++) applyStimulus(0, 100, 1'b1);
            for (int i = 0; i < 1500; i++) applyStimulus(70, 50, 1'b0);
            waited = 0;
            while (idx != RST_IDX && waited < 1000) begin
                applyStimulus(70, 50, 1'b0);
                waited++;
            end
            checkOutput("reach_reset_point", g, 32'(waited < 1000), 32'd1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            n_resets++;
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int i = 0; i < 400; i++) applyStimulus(60, 60, 1'b0);
            for (int i = 0; i < 3 * NB; i++) applyStimulus(100, 100, 1'b0);
            done = 1'b1;
        end
    end

    initial begin : finale
        wait (cfg[0].done && cfg[1].done);
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
